// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helper for the configuration chain loader.
// Poly 0x07, MSB-first bit-serial update.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic [7:0] crc8_step(
        input logic [7:0] c,
        input logic       b
    );
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear.
// Clear wins over enable.
module ccff_crc8
    import ccff_loader_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc <= CRC8_INIT;
        end else if (clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Byte-stream to configuration-chain serialiser with an optional
// loopback verify pass that CRC-checks the chain without altering it.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic       verify_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       ccff_shift_en,
    output logic       busy,
    output logic       config_done,
    output logic       crc_err,
    output logic [7:0] crc_out
);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] rem_bits;
    logic [3:0]       bits_left;
    logic [7:0]       sh;
    logic             head_q;
    logic             shift_en_q;
    logic             verify_q;
    logic             crc_err_q;
    logic [7:0]       crc;
    logic [7:0]       vcrc;

    logic             start_ok;
    logic             shifting;
    logic             handshake;
    logic             verifying;
    logic [CNT_W+3:0] rem_ext;
    logic [CNT_W+3:0] bl_ext;
    logic [CNT_W+3:0] avail;
    logic [3:0]       next_fill;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign shifting  = (state_q == LOAD) && (bits_left != 4'd0);
    assign verifying = (state_q == VERIFY);
    assign handshake = in_valid && in_ready;

    // Bits still owed to the chain beyond what sh already holds
    assign rem_ext   = {4'd0, rem_bits};
    assign bl_ext    = {{CNT_W{1'b0}}, bits_left};
    assign avail     = rem_ext - bl_ext;
    assign next_fill = (avail >= (CNT_W + 4)'(8)) ? 4'd8 : avail[3:0];

    assign in_ready = (state_q == LOAD) && (bits_left <= 4'd1)
                      && (rem_ext > bl_ext);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (rem_bits == '0) state_d = verify_q ? VERIFY : DONE;
            end
            VERIFY: begin
                if (rem_bits == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            rem_bits   <= '0;
            bits_left  <= 4'd0;
            sh         <= 8'h00;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            verify_q   <= 1'b0;
            crc_err_q  <= 1'b0;
        end else if (start_ok) begin
            rem_bits   <= CNT_W'(CHAIN_LEN);
            bits_left  <= 4'd0;
            shift_en_q <= 1'b0;
            verify_q   <= verify_en;
            crc_err_q  <= 1'b0;
        end else if (state_q == LOAD) begin
            shift_en_q <= shifting;
            if (shifting) begin
                head_q    <= sh[7];
                sh        <= {sh[6:0], 1'b0};
                bits_left <= bits_left - 4'd1;
                rem_bits  <= rem_bits - CNT_W'(1);
            end
            if (handshake) begin
                sh        <= in_data;
                bits_left <= next_fill;
            end
            // Reuse the bit counter to time the loopback rotation
            if (rem_bits == '0 && verify_q) begin
                rem_bits <= CNT_W'(CHAIN_LEN);
            end
        end else if (verifying) begin
            rem_bits <= rem_bits - CNT_W'(1);
            if (rem_bits == CNT_W'(1)) begin
                crc_err_q <= (crc8_step(vcrc, ccff_tail) != crc);
            end
        end
    end

    ccff_crc8 u_crc_load (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (start_ok),
        .en       (shifting),
        .din      (sh[7]),
        .crc      (crc)
    );

    ccff_crc8 u_crc_verify (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (start_ok),
        .en       (verifying),
        .din      (ccff_tail),
        .crc      (vcrc)
    );

    assign ccff_head     = verifying ? ccff_tail : head_q;
    assign ccff_shift_en = verifying || shift_en_q;
    assign busy          = (state_q == LOAD) || verifying;
    assign config_done   = (state_q == DONE);
    assign crc_err       = crc_err_q;
    assign crc_out       = crc;

endmodule
